// File: rtl/mul_ctrl_if.sv
// Handshake and Q-register bundle for the shift-add multiplier sequencer.
//
// Signals:
//   Mul_Ctrl_Start         request a multiply (sampled only while idle)
//   Mul_Ctrl_Multiplicand  operand B, captured on an accepted start
//   Mul_Ctrl_Multiplier    operand Q, forwarded to the Q register
//   Mul_Ctrl_Q_Lsb         LSB of the external multiplier shift register
//   Mul_Ctrl_Q_In          load data for the Q register
//   Mul_Ctrl_Q_Load        Q register load strobe
//   Mul_Ctrl_Q_Shift       Q register right-shift strobe
//   Mul_Ctrl_Busy          high whenever the sequencer is not idle
//   Mul_Ctrl_Done          one-cycle completion pulse
//   Mul_Ctrl_Product       2*WIDTH-bit result {A, P}
//
// Modports: master = requester plus Q register side, slave = mul_ctrl.
interface mul_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 Mul_Ctrl_Start;
  logic [WIDTH-1:0]     Mul_Ctrl_Multiplicand;
  logic [WIDTH-1:0]     Mul_Ctrl_Multiplier;
  logic                 Mul_Ctrl_Q_Lsb;
  logic [WIDTH-1:0]     Mul_Ctrl_Q_In;
  logic                 Mul_Ctrl_Q_Load;
  logic                 Mul_Ctrl_Q_Shift;
  logic                 Mul_Ctrl_Busy;
  logic                 Mul_Ctrl_Done;
  logic [2*WIDTH-1:0]   Mul_Ctrl_Product;

  modport master (
    output Mul_Ctrl_Start, Mul_Ctrl_Multiplicand, Mul_Ctrl_Multiplier, Mul_Ctrl_Q_Lsb,
    input  Mul_Ctrl_Q_In, Mul_Ctrl_Q_Load, Mul_Ctrl_Q_Shift, Mul_Ctrl_Busy,
           Mul_Ctrl_Done, Mul_Ctrl_Product
  );

  modport slave (
    input  Mul_Ctrl_Start, Mul_Ctrl_Multiplicand, Mul_Ctrl_Multiplier, Mul_Ctrl_Q_Lsb,
    output Mul_Ctrl_Q_In, Mul_Ctrl_Q_Load, Mul_Ctrl_Q_Shift, Mul_Ctrl_Busy,
           Mul_Ctrl_Done, Mul_Ctrl_Product
  );
endinterface

// File: rtl/mul_ctrl.sv
// Sequencer and accumulator for a WIDTH-bit shift-add multiplier.
// Drives load/shift strobes of an external multiplier shift register,
// samples its LSB during each ADD step, and assembles the product {A, P}.
//
// Ports:
//   Mul_Ctrl_Clock  sole clock, rising edge
//   Mul_Ctrl_Reset  synchronous, active-high reset
//   bus             mul_ctrl_if.slave (start/done handshake, Q register controls,
//                   operands and product)
module mul_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic     Mul_Ctrl_Clock,
  input  logic     Mul_Ctrl_Reset,
  mul_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_reg;
  logic             c_reg;
  logic [WIDTH-1:0] p_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   sum;
  logic             accept;
  logic             q_load;
  logic             q_shift;
  logic             busy;
  logic             done;

  assign sum = {1'b0, a_reg} + {1'b0, b_reg};

  // State register
  always_ff @(posedge Mul_Ctrl_Clock) begin
    if (Mul_Ctrl_Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode. Strobes are gated by reset so the Q
  // register never moves while reset is held, whatever state we are in.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    q_load     = 1'b0;
    q_shift    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = bus.Mul_Ctrl_Start && !Mul_Ctrl_Reset;
        q_load = accept;
        if (bus.Mul_Ctrl_Start) begin
          state_next = ADD;
        end
      end
      ADD: begin
        busy       = !Mul_Ctrl_Reset;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy       = !Mul_Ctrl_Reset;
        q_shift    = !Mul_Ctrl_Reset;
        state_next = (cnt_reg == CW'(1)) ? DONE : ADD;
      end
      DONE: begin
        busy       = !Mul_Ctrl_Reset;
        done       = !Mul_Ctrl_Reset;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: B/A/C/P/CNT
  always_ff @(posedge Mul_Ctrl_Clock) begin
    if (Mul_Ctrl_Reset) begin
      b_reg   <= '0;
      a_reg   <= '0;
      c_reg   <= 1'b0;
      p_reg   <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Mul_Ctrl_Start) begin
            b_reg   <= bus.Mul_Ctrl_Multiplicand;
            a_reg   <= '0;
            c_reg   <= 1'b0;
            p_reg   <= '0;
            cnt_reg <= CW'(WIDTH);
          end
        end
        ADD: begin
          if (bus.Mul_Ctrl_Q_Lsb) begin
            {c_reg, a_reg} <= sum;
          end
        end
        SHIFT: begin
          // The carry becomes A's new MSB; A's LSB moves into P.
          a_reg   <= {c_reg, a_reg[WIDTH-1:1]};
          p_reg   <= {a_reg[0], p_reg[WIDTH-1:1]};
          c_reg   <= 1'b0;
          cnt_reg <= cnt_reg - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Mul_Ctrl_Q_In     = bus.Mul_Ctrl_Multiplier;
  assign bus.Mul_Ctrl_Q_Load   = q_load;
  assign bus.Mul_Ctrl_Q_Shift  = q_shift;
  assign bus.Mul_Ctrl_Busy     = busy;
  assign bus.Mul_Ctrl_Done     = done;
  // Forced to zero while reset is held so the output is clean before the edge.
  assign bus.Mul_Ctrl_Product  = Mul_Ctrl_Reset ? '0 : {a_reg, p_reg};

endmodule
